// File: rtl/config_word_packer.sv
// config_word_packer
//   Hunts for the bitstream sync word in a byte stream, then packs bytes
//   MSB-first into 32-bit words and drives the eFPGA self-write port with
//   one-cycle strobes, each followed by a fixed idle gap. Sessions end on
//   byte-inactivity timeout or abort.
//
//   Optional build macro: CONFIG_PACKER_CHECKSUM_EN
//     defined   : checksum_o is a wrapping 32-bit sum of every emitted word
//     undefined : checksum_o is constant 0
//
// Ports
//   clk_system_i         system clock, rising edge
//   reset_i              synchronous active-high reset
//   byte_data_i/valid_i  incoming byte stream
//   byte_ready_o         byte accepted when valid and ready are both high
//   abort_i              ends the session, back to hunting
//   efpga_write_data_o   configuration word, held between strobes
//   efpga_write_strobe_o one-cycle write pulse
//   locked_o             session active
//   timeout_o            pulse: session ended by inactivity timeout
//   partial_drop_o       pulse: 1-3 bytes of an incomplete word discarded
//   word_count_o         words emitted this session (sync included), saturating
//   checksum_o           running word sum (see macro above)
module config_word_packer #(
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter int          STROBE_GAP     = 2,
    parameter int          TIMEOUT_CYCLES = 1_200_000,
    parameter int          TIMEOUT_WIDTH  = 21
) (
    input  logic        clk_system_i,
    input  logic        reset_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        abort_i,
    output logic [31:0] efpga_write_data_o,
    output logic        efpga_write_strobe_o,
    output logic        locked_o,
    output logic        timeout_o,
    output logic        partial_drop_o,
    output logic [15:0] word_count_o,
    output logic [31:0] checksum_o
);

    typedef enum logic [1:0] {HUNT, COLLECT, EMIT, GAP} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [31:0]              window;
    logic [1:0]               byte_cnt;
    logic [3:0]               gap_cnt;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt;

    logic        xfer;
    logic [31:0] window_shift;
    logic        sync_hit;
    logic        word_done;
    logic        idle_expire;
    logic        gap_done;

    assign xfer         = byte_valid_i & byte_ready_o;
    assign window_shift = {window[23:0], byte_data_i};
    assign sync_hit     = xfer && (state == HUNT) && (window_shift == SYNC_WORD);
    assign word_done    = xfer && (state == COLLECT) && (byte_cnt == 2'd3);
    // Fires on the TIMEOUT_CYCLES-th consecutive idle COLLECT cycle; abort wins.
    assign idle_expire  = (state == COLLECT) && !xfer && !abort_i &&
                          (idle_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    // Unreachable when STROBE_GAP is 0, since GAP is then never entered.
    assign gap_done     = (gap_cnt == 4'(STROBE_GAP - 1));

    // State register
    always_ff @(posedge clk_system_i) begin
        if (reset_i) state <= HUNT;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (sync_hit) state_next = EMIT;
            COLLECT: begin
                if (abort_i || idle_expire) state_next = HUNT;
                else if (word_done)         state_next = EMIT;
            end
            EMIT: begin
                if (abort_i)             state_next = HUNT;
                else if (STROBE_GAP > 0) state_next = GAP;
                else                     state_next = COLLECT;
            end
            GAP: begin
                if (abort_i)       state_next = HUNT;
                else if (gap_done) state_next = COLLECT;
            end
            default: state_next = HUNT;
        endcase
    end

    // Outputs decoded from state; bytes are refused during abort and reset.
    always_comb begin
        byte_ready_o         = 1'b0;
        efpga_write_strobe_o = 1'b0;
        locked_o             = 1'b0;
        case (state)
            HUNT:    byte_ready_o = !abort_i && !reset_i;
            COLLECT: begin
                byte_ready_o = !abort_i && !reset_i;
                locked_o     = 1'b1;
            end
            EMIT: begin
                efpga_write_strobe_o = 1'b1;
                locked_o             = 1'b1;
            end
            GAP:     locked_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_system_i) begin
        if (reset_i) begin
            window             <= '0;
            byte_cnt           <= '0;
            gap_cnt            <= '0;
            idle_cnt           <= '0;
            efpga_write_data_o <= '0;
            word_count_o       <= '0;
            timeout_o          <= 1'b0;
            partial_drop_o     <= 1'b0;
        end else begin
            timeout_o      <= 1'b0;
            partial_drop_o <= 1'b0;

            case (state)
                HUNT: begin
                    if (abort_i)   window <= '0;
                    else if (xfer) window <= window_shift;
                end
                COLLECT: begin
                    if (abort_i || idle_expire) begin
                        window         <= '0;
                        byte_cnt       <= '0;
                        timeout_o      <= idle_expire;
                        partial_drop_o <= (byte_cnt != 2'd0);
                    end else if (xfer) begin
                        window   <= window_shift;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: if (abort_i) window <= '0;
            endcase

            if (state == COLLECT && !xfer && !abort_i && !idle_expire)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;

            if (state == GAP && !gap_done && !abort_i) gap_cnt <= gap_cnt + 4'd1;
            else                                        gap_cnt <= '0;

            if (sync_hit) begin
                efpga_write_data_o <= SYNC_WORD;
                word_count_o       <= 16'd1;
            end else if (word_done) begin
                efpga_write_data_o <= window_shift;
                if (word_count_o != 16'hFFFF) word_count_o <= word_count_o + 16'd1;
            end
        end
    end

`ifdef CONFIG_PACKER_CHECKSUM_EN
    // sync_emit marks the EMIT cycle of the sync word, whose contribution
    // is loaded directly on the match so it is not summed twice.
    logic sync_emit;

    always_ff @(posedge clk_system_i) begin
        if (reset_i) begin
            checksum_o <= '0;
            sync_emit  <= 1'b0;
        end else begin
            sync_emit <= sync_hit;
            if (sync_hit)
                checksum_o <= SYNC_WORD;
            else if (state == EMIT && !sync_emit)
                checksum_o <= checksum_o + efpga_write_data_o;
        end
    end
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_config_word_packer.sv
module tb_config_word_packer;

    localparam logic [31:0] SYNC       = 32'hFAB0_FAB1;
    localparam int          STROBE_GAP = 2;
    localparam int          TOC        = 50;
    localparam int          TW         = 8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  byte_data_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        abort_i = 1'b0;
    logic [31:0] efpga_write_data_o;
    logic        efpga_write_strobe_o;
    logic        locked_o;
    logic        timeout_o;
    logic        partial_drop_o;
    logic [15:0] word_count_o;
    logic [31:0] checksum_o;

    config_word_packer #(
        .SYNC_WORD(SYNC), .STROBE_GAP(STROBE_GAP),
        .TIMEOUT_CYCLES(TOC), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk_system_i(clk), .reset_i(reset_i),
        .byte_data_i(byte_data_i), .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o), .abort_i(abort_i),
        .efpga_write_data_o(efpga_write_data_o),
        .efpga_write_strobe_o(efpga_write_strobe_o),
        .locked_o(locked_o), .timeout_o(timeout_o),
        .partial_drop_o(partial_drop_o), .word_count_o(word_count_o),
        .checksum_o(checksum_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] wc;
        logic [31:0] cs;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference model: session state over the accepted byte stream.
    bit          m_locked = 0;
    logic [31:0] m_hist = '0;
    logic [7:0]  m_pend[$];
    int          m_wc = 0;
    logic [31:0] m_cs = '0;
    int          exp_to = 0, exp_drop = 0, seen_to = 0, seen_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [31:0] w);
        exp_t e;
        e.data = w;
        e.wc   = 16'(m_wc);
`ifdef CONFIG_PACKER_CHECKSUM_EN
        e.cs   = m_cs;
`else
        e.cs   = '0;
`endif
        sb.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (!m_locked) begin
            m_hist = {m_hist[23:0], b};
            if (m_hist == SYNC) begin
                m_locked = 1;
                m_wc     = 1;
                m_cs     = SYNC;
                m_pend.delete();
                push_exp(SYNC);
            end
        end else begin
            m_pend.push_back(b);
            if (m_pend.size() == 4) begin
                w = {m_pend[0], m_pend[1], m_pend[2], m_pend[3]};
                m_pend.delete();
                if (m_wc < 65535) m_wc++;
                m_cs = m_cs + w;
                push_exp(w);
            end
        end
    endfunction

    function automatic void model_end(input bit by_timeout);
        if (m_locked && m_pend.size() != 0) exp_drop++;
        if (by_timeout) exp_to++;
        m_locked = 0;
        m_hist   = '0;
        m_pend.delete();
    endfunction

    // Monitor: scoreboard pops on every strobe; gap and pulse tracking.
    logic [31:0] cs_exp = '0;
    bit          cs_pend = 0;
    int          gap_run = 0;

    always @(negedge clk) begin
        exp_t e;
        if (cs_pend) begin
            check("checksum", checksum_o, cs_exp);
            cs_pend = 0;
        end
        if (timeout_o)      seen_to++;
        if (partial_drop_o) seen_drop++;
        if (reset_i) gap_run = 0;
        else if (gap_run > 0) begin
            if (abort_i) gap_run = 0;
            else if (!byte_ready_o) gap_run++;
            else begin
                if (locked_o) check("ready_low_after_strobe", gap_run, 1 + STROBE_GAP);
                gap_run = 0;
            end
        end
        if (efpga_write_strobe_o && !reset_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=%h expected=none", efpga_write_data_o);
            end else begin
                e = sb.pop_front();
                check("write_data", efpga_write_data_o, e.data);
                check("word_count", {16'h0, word_count_o}, {16'h0, e.wc});
                cs_exp  = e.cs;
                cs_pend = 1;
            end
            gap_run = 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_data_i  = b;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (byte_ready_o) begin
                model_byte(b);
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept actual=not_ready expected=ready");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_abort();
        byte_valid_i = 1'b0;
        abort_i      = 1'b1;
        model_end(0);
        @(posedge clk);
        #1;
        abort_i = 1'b0;
    endtask

    task automatic do_reset();
        byte_valid_i = 1'b0;
        reset_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready",   {31'h0, byte_ready_o}, 32'h0);
        check("rst_data",    efpga_write_data_o, 32'h0);
        check("rst_strobe",  {31'h0, efpga_write_strobe_o}, 32'h0);
        check("rst_locked",  {31'h0, locked_o}, 32'h0);
        check("rst_timeout", {31'h0, timeout_o}, 32'h0);
        check("rst_drop",    {31'h0, partial_drop_o}, 32'h0);
        check("rst_wc",      {16'h0, word_count_o}, 32'h0);
        check("rst_cs",      checksum_o, 32'h0);
        check("rst_sb_empty", sb.size(), 0);
        sb.delete();
        m_locked = 0;
        m_hist   = '0;
        m_pend.delete();
        m_wc = 0;
        m_cs = '0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int to0, dr0, r;
        logic [31:0] cs6;

        do_reset();

        // Basic packing with valid held high
        send_word(SYNC);
        send_word(32'h1122_3344);
        idle(6);
        check("t1_word_count", {16'h0, word_count_o}, 32'd2);
        check("t1_sb_empty", sb.size(), 0);
        do_abort();

        // Noise before the sync word
        send_byte(8'h00); send_byte(8'hFA); send_byte(8'hFA);
        send_byte(8'hB0); send_byte(8'hFA);
        idle(1);
        @(negedge clk);
        check("t2_unlocked_before", {31'h0, locked_o}, 32'h0);
        @(posedge clk); #1;
        send_byte(8'hB1);
        idle(2);
        check("t2_locked_after", {31'h0, locked_o}, 32'h1);
        check("t2_word_count", {16'h0, word_count_o}, 32'd1);

        // Timeout with a partial word
        to0 = seen_to;
        dr0 = seen_drop;
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TOC - 5);
        check("t3_still_locked", {31'h0, locked_o}, 32'h1);
        check("t3_no_early_timeout", seen_to, to0);
        idle(10);
        model_end(1);
        check("t3_timeout_pulses", seen_to, to0 + 1);
        check("t3_drop_pulses", seen_drop, dr0 + 1);
        check("t3_unlocked", {31'h0, locked_o}, 32'h0);

        // Abort during the EMIT cycle of word 2
        send_word(SYNC);
        send_word(32'h5566_7788);
        do_abort();
        @(negedge clk);
        check("t4_locked_drop", {31'h0, locked_o}, 32'h0);
        @(posedge clk); #1;
        send_word(32'hDEAD_BEEF);
        idle(5);
        check("t4_unlocked", {31'h0, locked_o}, 32'h0);

        // Reset mid-word, then re-sync
        send_word(SYNC);
        send_byte(8'h01);
        send_byte(8'h02);
        do_reset();
        send_word(SYNC);
        send_word(32'h0102_0304);
        idle(4);

        // Checksum wrap and sync pattern inside data
        do_abort();
        send_word(SYNC);
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        idle(4);
`ifdef CONFIG_PACKER_CHECKSUM_EN
        cs6 = 32'hFAB0_FAB1;
`else
        cs6 = 32'h0;
`endif
        check("t6_checksum", checksum_o, cs6);
        send_word(SYNC);
        idle(4);
        check("t6_no_resync_wc", {16'h0, word_count_o}, 32'd4);
        do_abort();

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send_byte(8'($urandom));
            else if (r < 72) send_word(SYNC);
            else if (r < 86) idle($urandom_range(1, 8));
            else if (r < 90) do_abort();
            else             send_word($urandom);
        end
        idle(10);
        do_abort();
        idle(5);

        check("end_sb_empty", sb.size(), 0);
        check("end_timeouts", seen_to, exp_to);
        check("end_drops", seen_drop, exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
